aud_player: RTL and testbench

- Stage directly downstream of AudDSP. Takes one 16-bit mono sample per audio frame over the DSP's en/ack handshake.
- Serialises that sample MSB-first onto the codec DAC data line (WM8731, I2S mode). The same sample goes to both left and right channels.
- Runs on the system clock. Codec BCLK and DACLRCK are sampled inputs, synchronised and edge-detected inside the block.

---
 rtl/aud_player.sv | 170 +++++++++++++++++
 tb/tb_aud_player.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/aud_player.sv
// -----------------------------------------------------------------------------
// aud_player
//   Takes one mono sample per audio frame from AudDSP over an en/ack handshake.
//   It shifts the sample MSB-first onto the WM8731 DAC data line in I2S
//   format. Left and right channels carry the same word.
//   Codec BCLK and DACLRCK are asynchronous inputs. They are synchronised and
//   edge-detected on i_clk.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_bclk       codec bit clock (async)
//   i_daclrck    codec DAC LR clock (async), low = left, high = right
//   i_en         sample valid from AudDSP
//   i_dac_data   sample from AudDSP, stable while i_en=1
//   i_mute       send zeros instead of the sample; the handshake still completes
//   o_ack        one-cycle pulse: sample accepted at a left-channel edge
//   o_underrun   one-cycle pulse: left-channel edge arrived with i_en=0
//   o_aud_dacdat registered serial data to the codec
// -----------------------------------------------------------------------------
module aud_player #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bclk,
  input  logic              i_daclrck,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_dac_data,
  input  logic              i_mute,
  output logic              o_ack,
  output logic              o_underrun,
  output logic              o_aud_dacdat
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SHIFT,
    PAD
  } state_t;

  // Synchroniser chains plus one history flop each, for edge detection.
  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lrck_sync;
  logic                   r_bclk_hist;
  logic                   r_lrck_hist;

  // NOTE: sequential state is updated only with non-blocking assignments.
  // Otherwise a later stage in the chain would see this cycle's value
  // instead of last cycle's value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_bclk_hist <= 1'b0;
      r_lrck_hist <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i_bclk};
      r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], i_daclrck};
      r_bclk_hist <= r_bclk_sync[SYNC_STAGES-1];
      r_lrck_hist <= r_lrck_sync[SYNC_STAGES-1];
    end
  end

  logic w_bfall;
  logic w_lfall;
  logic w_lrise;

  assign w_bfall = r_bclk_hist & ~r_bclk_sync[SYNC_STAGES-1];
  assign w_lfall = r_lrck_hist & ~r_lrck_sync[SYNC_STAGES-1];
  assign w_lrise = ~r_lrck_hist & r_lrck_sync[SYNC_STAGES-1];

  state_t            r_state;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_bitcnt;
  logic              r_dacdat;
  logic              r_ack;
  logic              r_underrun;

  state_t            w_state_nxt;
  logic [DATA_W-1:0] w_hold_nxt;
  logic [DATA_W-1:0] w_shreg_nxt;
  logic [CNT_W-1:0]  w_bitcnt_nxt;
  logic              w_dacdat_nxt;
  logic              w_ack_nxt;
  logic              w_underrun_nxt;

  // Next-state logic. An LRCK edge takes priority over a coincident bfall.
  // That bfall is consumed by the edge. This gives the I2S one-BCLK delay
  // and truncates a word that is still shifting.
  always_comb begin
    // NOTE: every output of this block gets a default first. Any path that
    // left one unassigned would infer a latch.
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_shreg_nxt    = r_shreg;
    w_bitcnt_nxt   = r_bitcnt;
    w_dacdat_nxt   = r_dacdat;
    w_ack_nxt      = 1'b0;
    w_underrun_nxt = 1'b0;

    if (w_lfall) begin
      if (i_en) begin
        w_hold_nxt = i_mute ? '0 : i_dac_data;
      end else begin
        w_hold_nxt = '0;
      end
      w_shreg_nxt    = w_hold_nxt;
      w_ack_nxt      = i_en;
      w_underrun_nxt = ~i_en;
      w_state_nxt    = ARM;
    end else if (w_lrise && r_state != IDLE) begin
      // The right channel repeats the held left sample.
      w_shreg_nxt = r_hold;
      w_state_nxt = ARM;
    end else if (w_bfall) begin
      case (r_state)
        ARM: begin
          w_dacdat_nxt = r_shreg[DATA_W-1];
          w_shreg_nxt  = {r_shreg[DATA_W-2:0], 1'b0};
          w_bitcnt_nxt = CNT_W'(DATA_W - 1);
          w_state_nxt  = SHIFT;
        end
        SHIFT: begin
          if (r_bitcnt == '0) begin
            w_dacdat_nxt = 1'b0;
            w_state_nxt  = PAD;
          end else begin
            w_dacdat_nxt = r_shreg[DATA_W-1];
            w_shreg_nxt  = {r_shreg[DATA_W-2:0], 1'b0};
            w_bitcnt_nxt = r_bitcnt - 1'b1;
          end
        end
        default: begin
          w_dacdat_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_dacdat   <= 1'b0;
      r_ack      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_dacdat   <= w_dacdat_nxt;
      r_ack      <= w_ack_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  assign o_ack        = r_ack;
  assign o_underrun   = r_underrun;
  assign o_aud_dacdat = r_dacdat;

endmodule

// File: tb/tb_aud_player.sv
// -----------------------------------------------------------------------------
// tb_aud_player
//   Drives BCLK (4 i_clk per phase) and DACLRCK, which switches on BCLK
//   falling edges like a real codec master. Each BCLK period is checked
//   against a reference model that works in terms of audio frames.
//   The model counts BCLK periods j since the last LRCK edge and derives the
//   expected serial bit:
//   - j = 0: the pin still holds the previous bit.
//   - j = 1..DATA_W: word bit DATA_W-j.
//   - after that: 0.
//   - before the first left edge following reset: 0.
// -----------------------------------------------------------------------------
module tb_aud_player;

  localparam int DATA_W = 16;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              bclk  = 1'b1;
  logic              lrck  = 1'b1;
  logic              en    = 1'b0;
  logic              mute  = 1'b0;
  logic [DATA_W-1:0] data  = '0;
  logic              o_ack;
  logic              o_underrun;
  logic              o_dacdat;

  always #5 clk = ~clk;

  aud_player #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_bclk      (bclk),
    .i_daclrck   (lrck),
    .i_en        (en),
    .i_dac_data  (data),
    .i_mute      (mute),
    .o_ack       (o_ack),
    .o_underrun  (o_underrun),
    .o_aud_dacdat(o_dacdat)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Frame-level reference model state.
  bit              m_active   = 1'b0;
  logic [DATA_W-1:0] m_word   = '0;
  logic [DATA_W-1:0] m_left   = '0;
  int              m_j        = 0;
  logic            m_carry    = 1'b0;
  logic            m_last_pin = 1'b0;
  logic            m_prev_lr  = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (j=%0d)", tag, obs, exp, m_j);
    end
  endtask

  // One BCLK period. It starts at a negedge of clk with BCLK falling and
  // optionally LRCK changing. It ends 8 clk later.
  task automatic period(input logic lr, input bit rst_here);
    logic exp_pin;
    bit   e_ack;
    bit   e_und;
    int   n_ack;
    int   n_und;
    int   ack_pos;
    e_ack = 1'b0;
    e_und = 1'b0;
    bclk  = 1'b0;
    lrck  = lr;
    if (lr != m_prev_lr) begin
      m_carry = m_last_pin;
      m_j     = 0;
      if (lr == 1'b0) begin
        m_active = 1'b1;
        m_word   = en ? (mute ? '0 : data) : '0;
        m_left   = m_word;
        e_ack    = en;
        e_und    = ~en;
      end else if (m_active) begin
        m_word = m_left;
      end
    end else begin
      m_j++;
    end
    m_prev_lr = lr;
    if (rst_here) begin
      m_active = 1'b0;
      m_carry  = 1'b0;
    end
    if (!m_active)           exp_pin = 1'b0;
    else if (m_j == 0)       exp_pin = m_carry;
    else if (m_j <= DATA_W)  exp_pin = m_word[DATA_W-m_j];
    else                     exp_pin = 1'b0;
    m_last_pin = exp_pin;

    n_ack   = 0;
    n_und   = 0;
    ack_pos = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (rst_here && k == 1) begin
        rst_n = 1'b0;
        #1;
        check("rst_async_pin", o_dacdat, 0);
        check("rst_async_ack", o_ack, 0);
      end
      if (rst_here && k == 2) rst_n = 1'b1;
      if (o_ack === 1'b1) begin
        n_ack++;
        if (ack_pos == 0) ack_pos = k;
      end
      if (o_underrun === 1'b1) n_und++;
      if (k == 4) begin
        check("pin_mid", o_dacdat, exp_pin);
        bclk = 1'b1;
      end
      if (k == 8) check("pin_end", o_dacdat, exp_pin);
    end
    check("ack_count", n_ack, e_ack);
    check("underrun_count", n_und, e_und);
    if (e_ack) check("ack_latency", ack_pos, 3);
  endtask

  task automatic do_frame(input logic [DATA_W-1:0] d, input bit e, input bit mu,
                          input int half, input int rst_at, input bit wiggle);
    data = d;
    en   = e;
    mute = mu;
    for (int p = 0; p < 2 * half; p++) begin
      if (p == 1 && wiggle) en = 1'($urandom_range(0, 1));
      period((p < half) ? 1'b0 : 1'b1, p == rst_at);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    bit                re;
    bit                rm;
    int                rh;

    repeat (3) @(negedge clk);
    check("reset_pin", o_dacdat, 0);
    check("reset_ack", o_ack, 0);
    check("reset_underrun", o_underrun, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic left/right.
    do_frame(16'hA5A5, 1'b1, 1'b0, 32, -1, 1'b0);
    do_frame(16'hA5A5, 1'b1, 1'b0, 32, -1, 1'b0);
    // Underrun.
    do_frame(16'h1234, 1'b0, 1'b0, 32, -1, 1'b0);
    // Mute, then unmuted.
    do_frame(16'h7FFF, 1'b1, 1'b1, 32, -1, 1'b0);
    do_frame(16'h7FFF, 1'b1, 1'b0, 32, -1, 1'b0);
    // Short half-frames, then normal again.
    repeat (3) do_frame(16'hFFFF, 1'b1, 1'b0, 10, -1, 1'b0);
    do_frame(16'hA5A5, 1'b1, 1'b0, 32, -1, 1'b0);
    // Reset after five bits of the left word.
    do_frame(16'hC3C3, 1'b1, 1'b0, 32, 6, 1'b0);
    // Handshake sequence.
    do_frame(16'h0001, 1'b1, 1'b0, 32, -1, 1'b0);
    do_frame(16'h0002, 1'b1, 1'b0, 32, -1, 1'b0);
    do_frame(16'h0003, 1'b1, 1'b0, 32, -1, 1'b0);
    // Random frames with random enable, mute and half-frame lengths.
    repeat (12) begin
      rd = DATA_W'($urandom);
      re = ($urandom_range(0, 3) != 0);
      rm = ($urandom_range(0, 3) == 0);
      rh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20)) : 32;
      do_frame(rd, re, rm, rh, -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
